// File: rtl/button_conditioner.sv
// Button front end: 2-flop sync, per-channel debounce FSM, registered strobes.
// Optional long-press strobe: define BUTTON_CONDITIONER_LONG_PRESS_EN.
module button_conditioner #(
   parameter int N_BTN       = 4,
   parameter int DB_CYCLES   = 4,
   parameter int HOLD_CYCLES = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw_n,
   output logic [N_BTN-1:0] btn_db_n,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_hold
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   typedef enum logic [1:0] {
      REL,
      PCHK,
      PRS,
      RCHK
   } state_t;

   logic [N_BTN-1:0] meta_n;
   logic [N_BTN-1:0] sync_n;

   // Two-flop synchroniser; idles released (high).
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_n <= '1;
         sync_n <= '1;
      end else begin
         meta_n <= btn_raw_n;
         sync_n <= meta_n;
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      state_t        state;
      logic [CW-1:0] cnt;
      logic          db_q;
      logic          press_q;
      logic          rel_q;

      // Debounce FSM: a level change is accepted only after a full stable run.
      always_ff @(posedge clk) begin
         if (rst) begin
            state   <= REL;
            cnt     <= '0;
            db_q    <= 1'b1;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            unique case (state)
               REL: begin
                  if (!sync_n[i]) begin
                     state <= PCHK;
                     cnt   <= CW'(1);
                  end
               end
               PCHK: begin
                  if (sync_n[i]) begin
                     state <= REL;
                     cnt   <= '0;
                  end else if (cnt == CW'(DB_CYCLES)) begin
                     state   <= PRS;
                     cnt     <= '0;
                     db_q    <= 1'b0;
                     press_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               PRS: begin
                  if (sync_n[i]) begin
                     state <= RCHK;
                     cnt   <= CW'(1);
                  end
               end
               RCHK: begin
                  if (!sync_n[i]) begin
                     state <= PRS;
                     cnt   <= '0;
                  end else if (cnt == CW'(DB_CYCLES)) begin
                     state <= REL;
                     cnt   <= '0;
                     db_q  <= 1'b1;
                     rel_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  state <= REL;
                  cnt   <= '0;
               end
            endcase
         end
      end

      assign btn_db_n[i]    = db_q;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = rel_q;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
      localparam int HW = $clog2(HOLD_CYCLES + 1);

      logic [HW-1:0] hcnt;
      logic          hold_q;

      // Hold timer runs only while settled in PRS; any exit or bounce clears it.
      always_ff @(posedge clk) begin
         if (rst) begin
            hcnt   <= '0;
            hold_q <= 1'b0;
         end else begin
            hold_q <= 1'b0;
            if (state == PRS && !sync_n[i]) begin
               if (hcnt != HW'(HOLD_CYCLES))
                  hcnt <= hcnt + 1'b1;
               if (hcnt == HW'(HOLD_CYCLES - 1))
                  hold_q <= 1'b1;
            end else begin
               hcnt <= '0;
            end
         end
      end

      assign btn_hold[i] = hold_q;
`else
      assign btn_hold[i] = 1'b0;
`endif
   end

`ifndef BUTTON_CONDITIONER_LONG_PRESS_EN
   localparam int hold_cycles_unused = HOLD_CYCLES;
`endif

endmodule
